// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the MIPS instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        KILL  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load takes precedence over bubble, otherwise holds.
// A bubble clears instr/valid but leaves pc4 untouched.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] pc4,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (load) begin
            if_id_instr <= instr;
            if_id_pc4   <= pc4;
            if_id_valid <= 1'b1;
        end else if (bubble) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, skid buffer and IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetched/bubble counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles,
`endif
    output logic              if_id_valid
);

    fetch_state_t      state;
    fetch_state_t      state_next;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pending;
    logic [ADDR_W-1:0] redirect_aligned;
    logic [31:0]       skid;
    logic [31:0]       ifid_instr_d;
    logic              ifid_load;
    logic              ifid_bubble;
    logic              pc_we;
    logic              skid_we;
    logic              pend_we;

    assign pc_inc           = pc + ADDR_W'(PC_INC);
    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign imem_addr        = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: begin
                if (!imem_ready && redirect_i)
                    state_next = KILL;
                else if (imem_ready && !redirect_i && stall_i)
                    state_next = HOLD;
            end
            KILL: begin
                if (imem_ready) state_next = FETCH;
            end
            HOLD: begin
                if (redirect_i || !stall_i) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_req     = 1'b1;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_instr_d = skid;
        pc_we        = 1'b0;
        pc_d         = pc_inc;
        skid_we      = 1'b0;
        pend_we      = 1'b0;
        unique case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect_i) begin
                        pc_we       = 1'b1;
                        pc_d        = redirect_aligned;
                        ifid_bubble = 1'b1;
                    end else if (stall_i) begin
                        skid_we = 1'b1;
                    end else begin
                        ifid_load    = 1'b1;
                        ifid_instr_d = imem_rdata;
                        pc_we        = 1'b1;
                    end
                end else if (redirect_i) begin
                    pend_we     = 1'b1;
                    ifid_bubble = 1'b1;
                end else begin
                    ifid_bubble = !stall_i;
                end
            end
            KILL: begin
                // A redirect coinciding with the response is the newest target.
                ifid_bubble = 1'b1;
                pend_we     = redirect_i;
                if (imem_ready) begin
                    pc_we = 1'b1;
                    pc_d  = redirect_i ? redirect_aligned : pending;
                end
            end
            HOLD: begin
                imem_req = 1'b0;
                if (redirect_i) begin
                    pc_we       = 1'b1;
                    pc_d        = redirect_aligned;
                    ifid_bubble = 1'b1;
                end else if (!stall_i) begin
                    ifid_load = 1'b1;
                    pc_we     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            skid    <= NOP_INSTR;
            pending <= '0;
        end else begin
            if (pc_we)   pc      <= pc_d;
            if (skid_we) skid    <= imem_rdata;
            if (pend_we) pending <= redirect_aligned;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .instr       (ifid_instr_d),
        .pc4         (pc_inc),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (ifid_load && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (ifid_bubble && !ifid_load && perf_bubbles != '1)
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule
